imem_loader: RTL
================

# imem_loader

Boot-time program loader sitting upstream of the instruction memory and the IAOQ fetch stage of the PA_RISC pipeline. Accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit words, writes them sequentially into instruction memory from byte address 0, and verifies an XOR checksum. Holds the pipeline stopped (`core_run` low) until a complete, checksum-clean image is loaded.

## Interface
- `MAX_WORDS`, 64: instruction memory capacity in words (256 bytes / 4)
- `ADDR_W`, 8: instruction memory byte-address width
- `clk`  in  1  pipeline clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE, ERROR
- `rx_valid`  in  1  byte available on `rx_data`
- `rx_data`  in  8  stream byte
- `rx_ready`  out  1  loader accepts a byte this cycle
- `im_we`  out  1  instruction memory write strobe, one cycle per word
- `im_addr`  out  ADDR_W  word-aligned byte address (`im_addr[1:0]` always 0)
- `im_wdata`  out  32  packed word
- `core_run`  out  1  high releases the pipeline; low holds IAOQ_FRONT/BACK at reset
- `busy`  out  1  high in COUNT, DATA, CHECK
- `done`  out  1  high in DONE
- `error`  out  1  high in ERROR
- `words_loaded`  out  7  words written in the current load

## Operation
- Byte accepted when `rx_valid && rx_ready`. `rx_ready` = busy; combinational from state only, never from `rx_valid`.
- States: IDLE, COUNT, DATA, CHECK, DONE, ERROR.
  - IDLE: `start` -> COUNT; clears `words_loaded`, checksum, byte lane.
  - COUNT: accepted byte N = word count. N==0 or N>MAX_WORDS -> ERROR; else latch N, -> DATA.
  - DATA: bytes packed MSB first (1st byte -> `[31:24]`, 4th -> `[7:0]`). 4th byte of a word -> write issued, lane wraps to 0, `words_loaded` += 1. After word N -> CHECK.
  - CHECK: accepted byte compared to XOR of all 4N payload bytes (count byte excluded). Equal -> DONE, else ERROR.
  - DONE: `core_run` high. `start` -> COUNT (drops `core_run` same edge).
  - ERROR: `core_run` low. `start` -> COUNT.
- `start` while busy: ignored.
- `im_addr` = 4 × (index of word being written), ADDR_W wide; index never exceeds MAX_WORDS-1, so no wrap.
- Checksum register 8-bit, XOR-accumulated on every accepted DATA byte.
- Memory contents are not cleared by reset or restart; a new load overwrites words 0..N-1 only.

## Timing
- Reset values: state IDLE, `rx_ready` 0, `im_we` 0, `im_addr` 0, `im_wdata` 0, `core_run` 0, `busy` 0, `done` 0, `error` 0, `words_loaded` 0.
- Reset mid-load: immediate return to IDLE; partial words discarded; already-written words remain in memory.
- `im_we`, `im_addr`, `im_wdata` registered: asserted the cycle after the edge that accepted a word's 4th byte, for exactly one cycle.
- State transitions occur on the edge that accepts the triggering byte; `rx_ready` for the next byte follows the new state (CHECK accepts the checksum byte the cycle after the last data byte).
- `core_run` registered from state: rises the cycle after entering DONE, i.e. ≥1 cycle after the final `im_we` pulse has retired.
- Throughput: one byte per cycle under continuous `rx_valid`; minimum load = 4N+2 accepted bytes.
- `rx_valid` gaps: no state change; lane and checksum hold.

## Structure
- Shared include header `loader_defs.v`: state encodings, `MAX_WORDS`, checksum width.
- One sub-module: `byte_packer` (lane counter, 32-bit shift register, word-complete pulse); FSM, checksum and address counter stay in `imem_loader`.
- Top level: `core_run` inverted and ANDed into IAOQ_FRONT/BACK reset; `im_*` drives instruction memory write port.

## Test plan
- N=1, bytes 0x01,0xE8,0x1F,0x1F,0xFE, checksum 0xE8^0x1F^0x1F^0xFE=0x16 -> one `im_we` at addr 0x00, data 0xE81F1FFE; DONE; `core_run` high; `words_loaded`=1.
- N=3, continuous stream, correct checksum -> `im_we` at 0x00, 0x04, 0x08 on consecutive word boundaries; `words_loaded`=3; `done`=1.
- N=2, checksum off by one bit -> both words written, ERROR, `core_run` stays 0; then `start` plus valid stream -> DONE.
- Count byte 0x00, then count byte 0x41 -> ERROR immediately after count byte, no `im_we`.
- `rx_valid` toggled randomly during N=4 load -> same words/addresses as continuous case; `start` pulse mid-DATA ignored.
- Reset asserted after 6 payload bytes of N=4 -> all outputs to reset values within the same cycle; subsequent full load succeeds.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int LDR_MAX_WORDS = 64;
    localparam int LDR_ADDR_W    = 8;
    localparam int LDR_CSUM_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    // A word count is usable only if it is non-zero and fits the memory.
    function automatic logic count_ok(input logic [7:0] n, input int max_words);
        return (n != 8'd0) && (int'(n) <= max_words);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes MSB-first into 32-bit words and flags the 4th byte.
module imem_loader_byte_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [1:0]  r_lane;
    logic [23:0] r_shift;

    // The completed word is presented combinationally so the loader can register it.
    assign o_word      = {r_shift, i_byte};
    assign o_word_done = i_accept && (r_lane == 2'd3);

    // Lane counter and shift register advance only on accepted bytes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lane  <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_clear) begin
            r_lane  <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_accept) begin
            r_lane  <= r_lane + 2'd1;
            r_shift <= {r_shift[15:0], i_byte};
        end else begin
            r_lane  <= r_lane;
            r_shift <= r_shift;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a counted, checksummed byte image and writes it into
// instruction memory, releasing the core only after a clean load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = LDR_MAX_WORDS,
    parameter int ADDR_W    = LDR_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    output logic              o_im_we,
    output logic [ADDR_W-1:0] o_im_addr,
    output logic [31:0]       o_im_wdata,
    output logic              o_core_run,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [6:0]        o_words_loaded
);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [6:0]              r_count;
    logic [6:0]              r_words;
    logic [LDR_CSUM_W-1:0]   r_csum;
    logic                    r_im_we;
    logic [ADDR_W-1:0]       r_im_addr;
    logic [31:0]             r_im_wdata;
    logic                    r_core_run;

    logic                    w_busy;
    logic                    w_accept;
    logic                    w_restart;
    logic                    w_count_ok;
    logic                    w_last_word;
    logic                    w_data_acc;
    logic                    w_word_done;
    logic [31:0]             w_word;
    logic [ADDR_W-1:0]       w_word_addr;

    assign w_busy      = (r_state == ST_COUNT) || (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign w_accept    = i_rx_valid && w_busy;
    assign w_restart   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                     (r_state == ST_ERROR));
    assign w_count_ok  = count_ok(i_rx_data, MAX_WORDS);
    assign w_last_word = ((r_words + 7'd1) == r_count);
    assign w_data_acc  = w_accept && (r_state == ST_DATA);
    assign w_word_addr = ADDR_W'({r_words, 2'b00});

    imem_loader_byte_packer u_packer (
        .i_clk       (i_clk),
        .i_rst_n     (i_reset),
        .i_clear     (w_restart),
        .i_accept    (w_data_acc),
        .i_byte      (i_rx_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    // Next-state logic; transitions happen on the edge accepting the triggering byte.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) w_state_nxt = ST_COUNT;
                else         w_state_nxt = r_state;
            end
            ST_COUNT: begin
                if (w_accept) w_state_nxt = w_count_ok ? ST_DATA : ST_ERROR;
                else          w_state_nxt = r_state;
            end
            ST_DATA: begin
                if (w_word_done && w_last_word) w_state_nxt = ST_CHECK;
                else                            w_state_nxt = r_state;
            end
            ST_CHECK: begin
                if (w_accept) w_state_nxt = (i_rx_data == r_csum) ? ST_DONE : ST_ERROR;
                else          w_state_nxt = r_state;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, checksum, word counter and registered memory-write port.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_count    <= 7'd0;
            r_words    <= 7'd0;
            r_csum     <= 8'd0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= 32'd0;
            r_core_run <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_im_we    <= 1'b0;
            // Delayed by one cycle after DONE so the last write has retired first.
            r_core_run <= (r_state == ST_DONE) && (w_state_nxt == ST_DONE);
            if (w_restart) begin
                r_words <= 7'd0;
                r_csum  <= 8'd0;
            end
            if (w_accept && (r_state == ST_COUNT) && w_count_ok) begin
                r_count <= i_rx_data[6:0];
            end
            if (w_data_acc) begin
                r_csum <= r_csum ^ i_rx_data;
            end
            if (w_word_done) begin
                r_im_we    <= 1'b1;
                r_im_addr  <= w_word_addr;
                r_im_wdata <= w_word;
                r_words    <= r_words + 7'd1;
            end
        end
    end

    assign o_rx_ready     = w_busy;
    assign o_busy         = w_busy;
    assign o_done         = (r_state == ST_DONE);
    assign o_error        = (r_state == ST_ERROR);
    assign o_im_we        = r_im_we;
    assign o_im_addr      = r_im_addr;
    assign o_im_wdata     = r_im_wdata;
    assign o_core_run     = r_core_run;
    assign o_words_loaded = r_words;

endmodule
